cmd_host: RTL and testbench
===========================

Name: cmd_host

Overview:
- Host-side command initiator for the logic-analyzer command/config block; it is the other end of the cmd/cmd_rdy/send_resp/resp_sent handshake.
- Accepts one request at a time from a host port (read register, write register, or channel dump).
- Drives the 16-bit command with cmd_rdy and collects each response byte, emulating the transmit time before acknowledging with resp_sent.
- For dumps, streams ENTRIES bytes out on rsp_data/rsp_valid, flags the final byte, and checks write ACK/NAK and timeouts.

Parameters:
- ENTRIES, 384, number of bytes returned by one dump command.
- LOG2, 9, width of the dump byte counter.
- SENT_DLY, 20, clk cycles between response capture and resp_sent pulse.
- TIMEOUT, 50000, max clk cycles waiting for cmd acceptance or a response byte.
- ACK, 8'hA5, expected write response.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active-high.
- req_valid  in  1  host request strobe.
- req_op  in  2  00 read, 01 write, 10 dump, 11 illegal.
- req_reg  in  6  register address; [2:0] is channel for dump.
- req_data  in  8  write data.
- req_ready  out  1  high only in IDLE.
- cmd  out  16  command word to responder.
- cmd_rdy  out  1  command valid.
- clr_cmd_rdy  in  1  responder consumed cmd.
- send_resp  in  1  one-cycle pulse, resp valid.
- resp  in  8  response byte.
- resp_sent  out  1  one-cycle pulse, response byte transmitted.
- rsp_data  out  8  captured response byte.
- rsp_valid  out  1  one-cycle pulse per captured byte.
- rsp_last  out  1  with rsp_valid on final byte of a request.
- rsp_err  out  1  one-cycle pulse on an error condition.
- timeout  out  1  one-cycle pulse on watchdog expiry.
- done  out  1  one-cycle pulse when a request completes.

Behaviour:
- Reset values: cmd=16'h0000, rsp_data=8'h00; all other outputs 0 except req_ready=1. State returns to IDLE and all counters clear. Reset mid-operation aborts the request with no done pulse.
- States: IDLE, ISSUE, WAIT_RESP, DRAIN.
- IDLE, on req_valid (req_ready=1):
  - op 00/01: latch cmd={op,req_reg,req_data}.
  - op 10: latch cmd={2'b10,3'b000,req_reg[2:0],8'h00}.
  - In these three cases, set byte counter=0 and go to ISSUE; cmd_rdy rises the next cycle.
  - op 11: no cmd change, stay in IDLE, pulse rsp_err and done the next cycle.
- ISSUE: cmd_rdy held high. On clr_cmd_rdy, cmd_rdy drops the next cycle and the state goes to WAIT_RESP. A send_resp seen in ISSUE is treated as an implicit clear and handled as in WAIT_RESP in the same cycle.
- WAIT_RESP, on send_resp:
  - rsp_data<=resp and rsp_valid pulses the next cycle.
  - rsp_last is set if op≠dump, or if the byte counter==ENTRIES-1.
  - For a write, rsp_err pulses with rsp_valid if resp≠ACK.
  - Then go to DRAIN.
- DRAIN: count SENT_DLY cycles, then pulse resp_sent for exactly 1 cycle.
  - If rsp_last was set: go to IDLE and pulse done in the same cycle as resp_sent.
  - Otherwise increment the byte counter and return to WAIT_RESP.
- send_resp during DRAIN or IDLE (overrun): byte dropped, rsp_err pulses, state unchanged.
- Watchdog: cycle counter clears on entry to ISSUE or WAIT_RESP and increments every cycle in those states.
  - When it reaches TIMEOUT: timeout and rsp_err pulse, cmd_rdy drops, go to IDLE, done pulses.
- cmd is held stable from ISSUE until the next accepted request.
- Dump byte counter is LOG2 bits wide and never exceeds ENTRIES-1.

Test Plan:
- Read: req op=00 reg=6'h07 → cmd=16'h0700, cmd_rdy high until clr_cmd_rdy. resp=8'h5A on send_resp → rsp_valid, rsp_data=8'h5A, rsp_last=1. resp_sent exactly 21 cycles after the send_resp cycle (20 DRAIN + 1); done with resp_sent.
- Write: op=01 reg=6'h0A data=8'h3C → cmd=16'h4A3C. resp=8'hA5 → no rsp_err. Repeat with resp=8'hEE → rsp_err pulses with rsp_valid.
- Dump: op=10 req_reg=6'h03 → cmd=16'h8300. Responder returns bytes 0..383 → 384 rsp_valid pulses in order and 384 resp_sent pulses; rsp_last and done only on byte 383.
- Timeout: op=00, responder never asserts clr_cmd_rdy → timeout and rsp_err pulse exactly 50000 cycles after cmd_rdy rises; cmd_rdy=0; req_ready=1 the next cycle.
- Illegal/overrun: op=11 → rsp_err and done, cmd_rdy stays 0. Extra send_resp during DRAIN → rsp_err, no extra rsp_valid.
- Reset mid-dump: assert rst_n at byte 100 → all outputs at reset values immediately; next request is accepted normally.

Source files
------------

// File: rtl/cmd_host.sv
// ---------------------------------------------------------------------------
// cmd_host
// Host-side command initiator for the logic-analyzer command/config block.
// Takes one host request at a time (register read, register write or channel
// dump), presents the 16-bit command to the responder with cmd_rdy, captures
// each response byte, waits out the emulated transmit time and acknowledges
// with resp_sent. Dumps return ENTRIES bytes; the last one is flagged.
// Writes check for the ACK byte. A watchdog aborts requests that stall.
//
// Ports
//   clk, rst_n          clock; asynchronous reset, active-high
//   req_valid/op/reg/   host request (op 00 read, 01 write, 10 dump,
//   req_data/req_ready  11 illegal); req_ready high only while idle
//   cmd, cmd_rdy        command word and its valid flag to the responder
//   clr_cmd_rdy         responder consumed cmd
//   send_resp, resp     responder response strobe and byte
//   resp_sent           one-cycle pulse: response byte transmitted
//   rsp_data/rsp_valid/ captured byte, its pulse and the final-byte flag
//   rsp_last
//   rsp_err, timeout,   one-cycle pulses: error, watchdog expiry,
//   done                request complete
// ---------------------------------------------------------------------------
module cmd_host #(
    parameter int unsigned ENTRIES  = 384,
    parameter int unsigned LOG2     = 9,
    parameter int unsigned SENT_DLY = 20,
    parameter int unsigned TIMEOUT  = 50000,
    parameter logic [7:0]  ACK      = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [1:0]  req_op,
    input  logic [5:0]  req_reg,
    input  logic [7:0]  req_data,
    output logic        req_ready,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    input  logic [7:0]  resp,
    output logic        resp_sent,
    output logic [7:0]  rsp_data,
    output logic        rsp_valid,
    output logic        rsp_last,
    output logic        rsp_err,
    output logic        timeout,
    output logic        done
);

    // One cycle counter serves both the watchdog (ISSUE/WAIT_RESP) and the
    // transmit delay (DRAIN); it clears on every state change.
    localparam int unsigned CNT_MAX = (TIMEOUT > SENT_DLY) ? TIMEOUT : SENT_DLY;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0]   TO_LAST   = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]   DLY_LAST  = CW'(SENT_DLY - 1);
    localparam logic [LOG2-1:0] LAST_BYTE = LOG2'(ENTRIES - 1);

    localparam logic [1:0] OP_RD   = 2'b00;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_DUMP = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RESP,
        DRAIN
    } state_e;

    state_e          state_q, state_d;
    logic [15:0]     cmd_q, cmd_d;
    logic [LOG2-1:0] byte_cnt_q, byte_cnt_d;
    logic [CW-1:0]   cyc_q, cyc_d;
    logic [7:0]      rsp_data_q, rsp_data_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_last_q, rsp_last_d;
    logic            rsp_err_q, rsp_err_d;
    logic            resp_sent_q, resp_sent_d;
    logic            timeout_q, timeout_d;
    logic            done_q, done_d;
    logic            is_last;

    // The opcode of the request in flight lives in the top bits of cmd_q,
    // which is held stable until the next accepted request.
    assign is_last = (cmd_q[15:14] != OP_DUMP) || (byte_cnt_q == LAST_BYTE);

    always_comb begin
        // NOTE: every variable gets a default before the case so that no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        state_d     = state_q;
        cmd_d       = cmd_q;
        byte_cnt_d  = byte_cnt_q;
        cyc_d       = cyc_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = 1'b0;
        rsp_last_d  = 1'b0;
        rsp_err_d   = 1'b0;
        resp_sent_d = 1'b0;
        timeout_d   = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                // A response with nothing outstanding is an overrun.
                if (send_resp) rsp_err_d = 1'b1;
                if (req_valid) begin
                    case (req_op)
                        OP_RD, OP_WR: begin
                            cmd_d      = {req_op, req_reg, req_data};
                            byte_cnt_d = '0;
                            state_d    = ISSUE;
                        end
                        OP_DUMP: begin
                            cmd_d      = {OP_DUMP, 3'b000, req_reg[2:0], 8'h00};
                            byte_cnt_d = '0;
                            state_d    = ISSUE;
                        end
                        default: begin
                            rsp_err_d = 1'b1;
                            done_d    = 1'b1;
                        end
                    endcase
                end
            end

            // A response arriving while still in ISSUE implies the responder
            // took the command, so both states capture it identically.
            ISSUE, WAIT_RESP: begin
                if (send_resp) begin
                    rsp_data_d  = resp;
                    rsp_valid_d = 1'b1;
                    rsp_last_d  = is_last;
                    if (cmd_q[15:14] == OP_WR && resp != ACK) rsp_err_d = 1'b1;
                    state_d = DRAIN;
                end else if (cyc_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    rsp_err_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end else if (state_q == ISSUE && clr_cmd_rdy) begin
                    state_d = WAIT_RESP;
                end
            end

            DRAIN: begin
                if (send_resp) rsp_err_d = 1'b1;
                if (cyc_q == DLY_LAST) begin
                    resp_sent_d = 1'b1;
                    if (is_last) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + LOG2'(1);
                        state_d    = WAIT_RESP;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            cyc_d = '0;
        end else if (state_q != IDLE) begin
            cyc_d = cyc_q + CW'(1);
        end
    end

    // rst_n is active-high here despite its name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= IDLE;
            cmd_q       <= 16'h0000;
            byte_cnt_q  <= '0;
            cyc_q       <= '0;
            rsp_data_q  <= 8'h00;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            resp_sent_q <= 1'b0;
            timeout_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of the others, independent of statement order.
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            byte_cnt_q  <= byte_cnt_d;
            cyc_q       <= cyc_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
            rsp_err_q   <= rsp_err_d;
            resp_sent_q <= resp_sent_d;
            timeout_q   <= timeout_d;
            done_q      <= done_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign cmd_rdy   = (state_q == ISSUE);
    assign cmd       = cmd_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_last  = rsp_last_q;
    assign rsp_err   = rsp_err_q;
    assign resp_sent = resp_sent_q;
    assign timeout   = timeout_q;
    assign done      = done_q;

endmodule

// File: tb/tb_cmd_host.sv
// ---------------------------------------------------------------------------
// tb_cmd_host
// Directed testbench for cmd_host. Plays the responder side of the
// cmd/cmd_rdy/send_resp/resp_sent handshake and the host request port.
// Inputs change 1 ns after the rising edge; outputs are read at that point,
// after the registers have settled.
// ---------------------------------------------------------------------------
module tb_cmd_host;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [5:0]  req_reg;
    logic [7:0]  req_data;
    logic        req_ready;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;
    logic        resp_sent;
    logic [7:0]  rsp_data;
    logic        rsp_valid;
    logic        rsp_last;
    logic        rsp_err;
    logic        timeout;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

    // Reset-state vector: cmd, rsp_data, req_ready, cmd_rdy, resp_sent,
    // rsp_valid, rsp_last, rsp_err, timeout, done.
    localparam logic [31:0] RESET_VEC = {16'h0000, 8'h00, 1'b1, 7'b0000000};

    cmd_host dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_op      (req_op),
        .req_reg     (req_reg),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .send_resp   (send_resp),
        .resp        (resp),
        .resp_sent   (resp_sent),
        .rsp_data    (rsp_data),
        .rsp_valid   (rsp_valid),
        .rsp_last    (rsp_last),
        .rsp_err     (rsp_err),
        .timeout     (timeout),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle; on return the DUT has seen it.
    task automatic do_req(input logic [1:0] op, input logic [5:0] r, input logic [7:0] d);
        req_valid = 1'b1;
        req_op    = op;
        req_reg   = r;
        req_data  = d;
        tick();
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_reg   = 6'h00;
        req_data  = 8'h00;
    endtask

    task automatic accept_cmd();
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
    endtask

    // Responder returns one byte, then the bench follows the DUT until
    // resp_sent (bounded). lat counts cycles from the send_resp cycle.
    task automatic send_byte(input logic [7:0] b, output int lat, output int n_valid,
                             output int n_err, output int n_last, output int n_done,
                             output logic err_v, output logic [7:0] data);
        send_resp = 1'b1;
        resp      = b;
        tick();
        send_resp = 1'b0;
        resp      = 8'h00;
        n_valid = 0;
        n_err   = 0;
        n_last  = 0;
        n_done  = 0;
        err_v   = 1'b0;
        data    = 8'h00;
        for (lat = 1; lat < 200; lat++) begin
            if (rsp_valid) begin
                n_valid++;
                data = rsp_data;
                if (rsp_last) n_last++;
                if (rsp_err) err_v = 1'b1;
            end
            if (rsp_err) n_err++;
            if (done) n_done++;
            if (resp_sent) break;
            tick();
        end
    endtask

    task automatic test_reset();
        logic [31:0] obs;
        rst_n = 1'b1;
        repeat (3) tick();
        obs = {cmd, rsp_data, req_ready, cmd_rdy, resp_sent, rsp_valid, rsp_last, rsp_err, timeout, done};
        n_cmp++;
        if (obs !== RESET_VEC) begin
            n_bad++;
            $display("FAIL reset_state: got %h expected %h", obs, RESET_VEC);
        end
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if (req_ready !== 1'b1 || cmd_rdy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: req_ready=%b cmd_rdy=%b expected 1/0", req_ready, cmd_rdy);
        end
    endtask

    task automatic test_read();
        int lat, nv, ne, nl, nd, hold_ok;
        logic ev;
        logic [7:0] dat;
        do_req(2'b00, 6'h07, 8'h00);
        n_cmp++;
        if (cmd !== 16'h0700 || cmd_rdy !== 1'b1 || req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL read_cmd: cmd=%h cmd_rdy=%b req_ready=%b expected 0700/1/0", cmd, cmd_rdy, req_ready);
        end
        hold_ok = 1;
        repeat (3) begin
            tick();
            if (cmd_rdy !== 1'b1) hold_ok = 0;
        end
        n_cmp++;
        if (hold_ok != 1) begin
            n_bad++;
            $display("FAIL read_cmd_hold: cmd_rdy dropped before clr_cmd_rdy, expected held high");
        end
        accept_cmd();
        n_cmp++;
        if (cmd_rdy !== 1'b0) begin
            n_bad++;
            $display("FAIL read_clr: cmd_rdy=%b expected 0", cmd_rdy);
        end
        tick();
        send_byte(8'h5A, lat, nv, ne, nl, nd, ev, dat);
        n_cmp++;
        if (dat !== 8'h5A || nv != 1 || nl != 1 || ne != 0) begin
            n_bad++;
            $display("FAIL read_rsp: data=%h valid=%0d last=%0d err=%0d expected 5a/1/1/0", dat, nv, nl, ne);
        end
        n_cmp++;
        if (lat != 21 || done !== 1'b1 || nd != 1) begin
            n_bad++;
            $display("FAIL read_sent: latency=%0d done=%b dones=%0d expected 21/1/1", lat, done, nd);
        end
        tick();
        n_cmp++;
        if (req_ready !== 1'b1 || resp_sent !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL read_idle: req_ready=%b resp_sent=%b done=%b expected 1/0/0", req_ready, resp_sent, done);
        end
    endtask

    task automatic test_write();
        int lat, nv, ne, nl, nd;
        logic ev;
        logic [7:0] dat;
        do_req(2'b01, 6'h0A, 8'h3C);
        n_cmp++;
        if (cmd !== 16'h4A3C || cmd_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL write_cmd: cmd=%h cmd_rdy=%b expected 4a3c/1", cmd, cmd_rdy);
        end
        accept_cmd();
        send_byte(8'hA5, lat, nv, ne, nl, nd, ev, dat);
        n_cmp++;
        if (ne != 0 || nv != 1 || nl != 1 || lat != 21 || nd != 1) begin
            n_bad++;
            $display("FAIL write_ack: err=%0d valid=%0d last=%0d latency=%0d done=%0d expected 0/1/1/21/1",
                     ne, nv, nl, lat, nd);
        end
        tick();
        // Back-to-back write answered while still in ISSUE (implicit clear).
        do_req(2'b01, 6'h0A, 8'h3C);
        send_byte(8'hEE, lat, nv, ne, nl, nd, ev, dat);
        n_cmp++;
        if (ne != 1 || ev !== 1'b1 || dat !== 8'hEE) begin
            n_bad++;
            $display("FAIL write_nak: err=%0d err_with_valid=%b data=%h expected 1/1/ee", ne, ev, dat);
        end
        n_cmp++;
        if (lat != 21 || nd != 1 || cmd_rdy !== 1'b0) begin
            n_bad++;
            $display("FAIL write_nak_done: latency=%0d done=%0d cmd_rdy=%b expected 21/1/0", lat, nd, cmd_rdy);
        end
        tick();
    endtask

    task automatic test_dump();
        int lat, nv, ne, nl, nd;
        int tot_valid, tot_sent, tot_last, tot_done, last_idx, done_idx;
        logic ev;
        logic [7:0] dat;
        tot_valid = 0; tot_sent = 0; tot_last = 0; tot_done = 0;
        last_idx = -1; done_idx = -1;
        do_req(2'b10, 6'h03, 8'h00);
        n_cmp++;
        if (cmd !== 16'h8300 || cmd_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL dump_cmd: cmd=%h cmd_rdy=%b expected 8300/1", cmd, cmd_rdy);
        end
        accept_cmd();
        for (int i = 0; i < 384; i++) begin
            send_byte(8'(i), lat, nv, ne, nl, nd, ev, dat);
            tot_valid += nv;
            tot_last  += nl;
            tot_done  += nd;
            if (lat == 21) tot_sent++;
            if (nl != 0) last_idx = i;
            if (nd != 0) done_idx = i;
            n_cmp++;
            if (dat !== 8'(i) || nv != 1 || lat != 21) begin
                n_bad++;
                $display("FAIL dump_byte %0d: data=%h valid=%0d latency=%0d expected %h/1/21",
                         i, dat, nv, lat, 8'(i));
            end
        end
        n_cmp++;
        if (tot_valid != 384 || tot_sent != 384) begin
            n_bad++;
            $display("FAIL dump_counts: valid=%0d sent=%0d expected 384/384", tot_valid, tot_sent);
        end
        n_cmp++;
        if (tot_last != 1 || last_idx != 383 || tot_done != 1 || done_idx != 383) begin
            n_bad++;
            $display("FAIL dump_last: lasts=%0d at %0d dones=%0d at %0d expected 1 at 383 / 1 at 383",
                     tot_last, last_idx, tot_done, done_idx);
        end
        tick();
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL dump_idle: req_ready=%b expected 1", req_ready);
        end
    endtask

    task automatic test_timeout();
        int n, drops;
        drops = 0;
        do_req(2'b00, 6'h11, 8'h00);
        // cmd_rdy rose at this edge; count cycles until the watchdog fires.
        for (n = 0; n < 50100; n++) begin
            if (timeout) break;
            if (!cmd_rdy) drops++;
            tick();
        end
        n_cmp++;
        if (n != 50000 || drops != 0) begin
            n_bad++;
            $display("FAIL timeout_latency: cycles=%0d early_drops=%0d expected 50000/0", n, drops);
        end
        n_cmp++;
        if (rsp_err !== 1'b1 || done !== 1'b1 || cmd_rdy !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_flags: rsp_err=%b done=%b cmd_rdy=%b expected 1/1/0", rsp_err, done, cmd_rdy);
        end
        tick();
        n_cmp++;
        if (req_ready !== 1'b1 || timeout !== 1'b0 || rsp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_after: req_ready=%b timeout=%b rsp_err=%b expected 1/0/0",
                     req_ready, timeout, rsp_err);
        end
    endtask

    task automatic test_illegal();
        do_req(2'b11, 6'h3F, 8'hFF);
        n_cmp++;
        if (rsp_err !== 1'b1 || done !== 1'b1 || cmd_rdy !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL illegal_flags: rsp_err=%b done=%b cmd_rdy=%b req_ready=%b expected 1/1/0/1",
                     rsp_err, done, cmd_rdy, req_ready);
        end
        n_cmp++;
        if (cmd !== 16'h1100) begin
            n_bad++;
            $display("FAIL illegal_cmd: cmd=%h expected 1100 (unchanged)", cmd);
        end
        tick();
        n_cmp++;
        if (rsp_err !== 1'b0 || done !== 1'b0 || cmd_rdy !== 1'b0) begin
            n_bad++;
            $display("FAIL illegal_pulse: rsp_err=%b done=%b cmd_rdy=%b expected 0/0/0", rsp_err, done, cmd_rdy);
        end
    endtask

    task automatic test_overrun();
        int lat, extra_valid;
        extra_valid = 0;
        // Overrun while idle.
        send_resp = 1'b1;
        resp      = 8'h44;
        tick();
        send_resp = 1'b0;
        n_cmp++;
        if (rsp_err !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun_idle: rsp_err=%b rsp_valid=%b req_ready=%b expected 1/0/1",
                     rsp_err, rsp_valid, req_ready);
        end
        tick();
        // Overrun during DRAIN of a read.
        do_req(2'b00, 6'h01, 8'h00);
        accept_cmd();
        send_resp = 1'b1;
        resp      = 8'h77;
        tick();
        send_resp = 1'b0;
        lat = 1;
        repeat (4) begin
            tick();
            lat++;
        end
        send_resp = 1'b1;
        resp      = 8'h99;
        tick();
        lat++;
        send_resp = 1'b0;
        n_cmp++;
        if (rsp_err !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 8'h77) begin
            n_bad++;
            $display("FAIL overrun_drain: rsp_err=%b rsp_valid=%b rsp_data=%h expected 1/0/77",
                     rsp_err, rsp_valid, rsp_data);
        end
        while (!resp_sent && lat < 200) begin
            tick();
            lat++;
            if (rsp_valid) extra_valid++;
        end
        n_cmp++;
        if (lat != 21 || done !== 1'b1 || extra_valid != 0) begin
            n_bad++;
            $display("FAIL overrun_sent: latency=%0d done=%b extra_valid=%0d expected 21/1/0",
                     lat, done, extra_valid);
        end
        tick();
    endtask

    task automatic test_reset_mid_dump();
        int lat, nv, ne, nl, nd, stray;
        logic ev;
        logic [7:0] dat;
        logic [31:0] obs;
        stray = 0;
        do_req(2'b10, 6'h3C, 8'hFF);
        n_cmp++;
        if (cmd !== 16'h8400) begin
            n_bad++;
            $display("FAIL rdump_cmd: cmd=%h expected 8400 (reg[5:3] and data ignored)", cmd);
        end
        accept_cmd();
        for (int i = 0; i < 100; i++) send_byte(8'(i), lat, nv, ne, nl, nd, ev, dat);
        send_resp = 1'b1;
        resp      = 8'd100;
        tick();
        send_resp = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
        obs = {cmd, rsp_data, req_ready, cmd_rdy, resp_sent, rsp_valid, rsp_last, rsp_err, timeout, done};
        n_cmp++;
        if (obs !== RESET_VEC) begin
            n_bad++;
            $display("FAIL rdump_async: got %h expected %h", obs, RESET_VEC);
        end
        #1;
        rst_n = 1'b0;
        repeat (30) begin
            tick();
            if (done || resp_sent || rsp_valid) stray++;
        end
        n_cmp++;
        if (stray != 0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rdump_quiet: stray_pulses=%0d req_ready=%b expected 0/1", stray, req_ready);
        end
        do_req(2'b00, 6'h05, 8'h00);
        n_cmp++;
        if (cmd !== 16'h0500 || cmd_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL rdump_next_cmd: cmd=%h cmd_rdy=%b expected 0500/1", cmd, cmd_rdy);
        end
        accept_cmd();
        send_byte(8'hC3, lat, nv, ne, nl, nd, ev, dat);
        n_cmp++;
        if (dat !== 8'hC3 || nl != 1 || lat != 21 || nd != 1) begin
            n_bad++;
            $display("FAIL rdump_next_rsp: data=%h last=%0d latency=%0d done=%0d expected c3/1/21/1",
                     dat, nl, lat, nd);
        end
        tick();
    endtask

    initial begin
        rst_n       = 1'b1;
        req_valid   = 1'b0;
        req_op      = 2'b00;
        req_reg     = 6'h00;
        req_data    = 8'h00;
        clr_cmd_rdy = 1'b0;
        send_resp   = 1'b0;
        resp        = 8'h00;
        #1;
        test_reset();
        test_read();
        test_write();
        test_dump();
        test_timeout();
        test_illegal();
        test_overrun();
        test_reset_mid_dump();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
